// File: rtl/branch_control_sequencer.sv
// Hardwired control-step sequencer for the conditional-branch instruction class.
// Walks fetch (T0-T2), condition evaluation (T3) and target/PC update (T4-T6) as Moore strobes.
module branch_control_sequencer #(
    parameter logic [4:0] OPCODE_BR  = 5'b10010,
    parameter int         WAIT_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    input  logic [31:0] bus_in,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zlowin,
    output logic        Zlowout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Gra,
    output logic        Rout,
    output logic        CONin,
    output logic        Yin,
    output logic        Cout,
    output logic        ADD,
    output logic        con_ff,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        timeout
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_FAULT
    } state_t;

    localparam logic [7:0] WAIT_MAX = 8'(WAIT_LIMIT);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [7:0] wait_inc;
    logic       con_ff_q, con_ff_d;
    logic       opcode_ok;
    logic       unused_ir_bits;

    function automatic logic cond_eval(input logic [1:0] sel, input logic [31:0] val);
        logic signed [31:0] sval;
        sval = $signed(val);
        case (sel)
            2'b00:   return (val == 32'd0);
            2'b01:   return (val != 32'd0);
            2'b10:   return (sval >= 0);
            default: return (sval < 0);
        endcase
    endfunction

    assign opcode_ok      = (ir[31:27] == OPCODE_BR);
    assign wait_inc       = wait_q + 8'd1;
    assign unused_ir_bits = ^{ir[26:21], ir[18:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wait_q   <= 8'd0;
            con_ff_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            con_ff_q <= con_ff_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        con_ff_d = con_ff_q;
        {PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MDRin} = '0;
        {MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD}          = '0;
        {done, illegal, timeout}                                  = '0;
        case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0: begin
                {PCout, MARin, IncPC, Zlowin} = '1;
                wait_d  = 8'd0;
                state_d = S_T1;
            end
            S_T1: begin
                {Zlowout, PCin, Read, MDRin} = '1;
                if (mem_ready) begin
                    state_d = S_T2;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_MAX) state_d = S_FAULT;
                end
            end
            S_T2: begin
                {MDRout, IRin} = '1;
                state_d = S_T3;
            end
            S_T3: begin
                {Gra, Rout, CONin} = '1;
                if (!opcode_ok) begin
                    {illegal, done} = '1;
                    state_d = S_IDLE;
                end else begin
                    con_ff_d = cond_eval(ir[20:19], bus_in);
                    state_d  = S_T4;
                end
            end
            S_T4: begin
                {PCout, Yin} = '1;
                state_d = S_T5;
            end
            S_T5: begin
                {Cout, ADD, Zlowin} = '1;
                state_d = S_T6;
            end
            S_T6: begin
                Zlowout = 1'b1;
                PCin    = con_ff_q;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_FAULT: begin
                {timeout, done} = '1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Nothing may leak out while reset is held, even mid-instruction.
        if (reset) begin
            {PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MDRin} = '0;
            {MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD}          = '0;
            {done, illegal, timeout}                                  = '0;
        end
    end

    assign con_ff = con_ff_q & ~reset;
    assign busy   = (state_q != S_IDLE) & ~reset;

endmodule

// File: tb/tb_branch_control_sequencer.sv
// Scoreboard bench: a driver queues per-cycle expected outputs from a phase-table model,
// and a negedge monitor compares whatever the sequencer presents against that queue.
module tb_branch_control_sequencer;

    localparam logic [15:0] S_PCOUT = 16'h8000, S_MARIN = 16'h4000, S_INCPC = 16'h2000,
                            S_ZLOWIN = 16'h1000, S_ZLOWOUT = 16'h0800, S_PCIN = 16'h0400,
                            S_READ = 16'h0200, S_MDRIN = 16'h0100, S_MDROUT = 16'h0080,
                            S_IRIN = 16'h0040, S_GRA = 16'h0020, S_ROUT = 16'h0010,
                            S_CONIN = 16'h0008, S_YIN = 16'h0004, S_COUT = 16'h0002,
                            S_ADD = 16'h0001;
    localparam int WAIT_LIM = 8;

    typedef struct {
        int          cyc;
        logic [20:0] vec;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset, start, mem_ready;
    logic [31:0] ir, bus_in;
    logic PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MDRin;
    logic MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD;
    logic con_ff, busy, done, illegal, timeout;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 0;
    logic mdl_con = 1'b0;
    ent_t exp_q[$];

    branch_control_sequencer #(.OPCODE_BR(5'b10010), .WAIT_LIMIT(WAIT_LIM)) dut (
        .clock(clock), .reset(reset), .start(start), .mem_ready(mem_ready),
        .ir(ir), .bus_in(bus_in),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zlowin(Zlowin),
        .Zlowout(Zlowout), .PCin(PCin), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Rout(Rout), .CONin(CONin),
        .Yin(Yin), .Cout(Cout), .ADD(ADD),
        .con_ff(con_ff), .busy(busy), .done(done), .illegal(illegal), .timeout(timeout)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic model_cond(input logic [1:0] sel, input logic [31:0] v);
        case (sel)
            2'd0:    return v == 0;
            2'd1:    return v != 0;
            2'd2:    return v < 32'h8000_0000;
            default: return v >= 32'h8000_0000;
        endcase
    endfunction

    function automatic ent_t mk(input int c, input logic [15:0] s, input logic con,
                                input logic d, input logic il, input logic to);
        ent_t e;
        e.cyc = c;
        e.vec = {s, con, 1'b1, d, il, to};
        return e;
    endfunction

    // Build the expected phase sequence, then drive one instruction cycle-by-cycle.
    task automatic run_txn(input logic [31:0] irv, input logic [31:0] busv, input int stall,
                           input bit never, input int rst_at, input int spa);
        ent_t seq[$];
        ent_t tmp;
        int   a, n, full_len, t4_idx, nt1;
        logic legal, c, old;
        a     = cyc + 1;
        legal = (irv[31:27] == 5'b10010);
        c     = model_cond(irv[20:19], busv);
        old   = mdl_con;
        n     = 0;
        nt1   = never ? WAIT_LIM : stall + 1;
        seq.push_back(mk(a + n, S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN, old, 0, 0, 0)); n++;
        for (int i = 0; i < nt1; i++) begin
            seq.push_back(mk(a + n, S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN, old, 0, 0, 0)); n++;
        end
        t4_idx = -1;
        if (never) begin
            seq.push_back(mk(a + n, 16'h0, old, 1, 0, 1)); n++;
        end else begin
            seq.push_back(mk(a + n, S_MDROUT | S_IRIN, old, 0, 0, 0)); n++;
            if (!legal) begin
                seq.push_back(mk(a + n, S_GRA | S_ROUT | S_CONIN, old, 1, 1, 0)); n++;
            end else begin
                seq.push_back(mk(a + n, S_GRA | S_ROUT | S_CONIN, old, 0, 0, 0)); n++;
                t4_idx = n;
                seq.push_back(mk(a + n, S_PCOUT | S_YIN, c, 0, 0, 0)); n++;
                seq.push_back(mk(a + n, S_COUT | S_ADD | S_ZLOWIN, c, 0, 0, 0)); n++;
                seq.push_back(mk(a + n, S_ZLOWOUT | (c ? S_PCIN : 16'h0), c, 1, 0, 0)); n++;
            end
        end
        full_len = n;
        if (rst_at >= 0)
            while (seq.size() > rst_at) tmp = seq.pop_back();
        foreach (seq[i]) exp_q.push_back(seq[i]);

        ir = irv; bus_in = busv; start = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < full_len; i++) begin
            @(posedge clock); #1;
            start     = (i == spa);
            mem_ready = never ? 1'b0 : (i >= 1 + stall);
            if (i == t4_idx) mdl_con = c;
            if (i == rst_at) begin
                reset = 1'b1; mdl_con = 1'b0;
                @(posedge clock); #1;
                reset = 1'b0; start = 1'b0; mem_ready = 1'b0;
                return;
            end
        end
        @(posedge clock); #1;
        start = 1'b0; mem_ready = 1'b0;
    endtask

    always @(negedge clock) begin
        logic [20:0] act;
        ent_t e;
        if (mon_en) begin
            act = {PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MDRin,
                   MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD,
                   con_ff, busy, done, illegal, timeout};
            if (busy || done) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_busy cyc=%0d got=%h want=idle", cyc, act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e.vec || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL step cyc=%0d got=%h want=%h at cyc %0d", cyc, act, e.vec, e.cyc);
                    end
                end
            end else begin
                total++;
                if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    bad++;
                    $display("FAIL missed_step cyc=%0d got=%h want=%h", cyc, act, e.vec);
                end else if (act !== {16'h0, mdl_con, 4'h0}) begin
                    bad++;
                    $display("FAIL idle_outputs cyc=%0d got=%h want=%h", cyc, act, {16'h0, mdl_con, 4'h0});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rir, rbus;
        logic [4:0]  op;
        int          sel, rst_at, spa;
        bit          nev;
        reset = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = '0; bus_in = '0;
        @(posedge clock); #1;
        mon_en = 1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        run_txn(32'h9110_0023, 32'h0000_0005, 0, 0, -1, -1);  // brpl taken
        run_txn(32'h9110_0023, 32'h8000_0000, 0, 0, -1, -1);  // brpl not taken
        run_txn(32'h9100_0023, 32'h0000_0000, 0, 0, -1, -1);  // brzr
        run_txn(32'h9108_0023, 32'h0000_0000, 0, 0, -1, -1);  // brnz
        run_txn(32'h9118_0023, 32'hFFFF_FFFF, 0, 0, -1, -1);  // brmi
        run_txn(32'h9110_0023, 32'h0000_0005, 3, 0, -1, -1);  // stall
        run_txn(32'h9110_0023, 32'h0000_0005, 0, 1, -1, -1);  // timeout
        run_txn(32'h0910_0023, 32'h0000_0005, 0, 0, -1, -1);  // illegal
        run_txn(32'h9110_0023, 32'h0000_0005, 0, 0, 4, -1);   // reset in T4
        run_txn(32'h9118_0023, 32'h8000_0001, 0, 0, -1, 5);   // start during T5
        repeat (2) @(posedge clock);
        #1;

        for (int t = 0; t < 40; t++) begin
            rir = $urandom;
            op  = 5'b10010;
            if ($urandom_range(0, 9) == 0) begin
                op = 5'($urandom);
                if (op == 5'b10010) op = 5'b10011;
            end
            rir[31:27] = op;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       rbus = 32'h0;
                1:       rbus = 32'hFFFF_FFFF;
                2:       rbus = $urandom;
                default: rbus = $urandom & 32'h7FFF_FFFF;
            endcase
            nev    = ($urandom_range(0, 9) == 0);
            rst_at = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 3) : -1;
            spa    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 6) : -1;
            run_txn(rir, rbus, $urandom_range(0, 5), nev, rst_at, spa);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
            end
        end

        repeat (3) @(posedge clock);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
